mem_xfer_ctrl: RTL

Parametrised sequencer for the memory transfer datapath. It first loads a block of words into memory A. It then copies a strided subset of A into consecutive locations of memory B. It drives the A/B write enables, increment strobes and addresses. It sits between the transfer datapath and the system bus and supports a start/done handshake or a free-running auto-restart mode.

---
 rtl/mem_xfer_pkg.sv | 15 +
 rtl/step_counter.sv | 43 ++++
 rtl/mem_xfer_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_xfer_pkg.sv
// Shared types for the memory transfer sequencer: state encoding doubles as the phase output.
package mem_xfer_pkg;

    localparam int unsigned PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEEK = 3'd2,
        ST_WRB  = 3'd3,
        ST_STEP = 3'd4,
        ST_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/step_counter.sv
// Address register with synchronous clear, parallel load, unit step and parameterised step.
module step_counter #(
    parameter int unsigned W    = 4,
    parameter int unsigned STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc_one,
    input  logic         inc_step,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // Clear beats load beats either step; arithmetic wraps at W bits.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (ld) begin
            q_d = ld_val;
        end else if (inc_step) begin
            q_d = q_q + W'(STEP);
        end else if (inc_one) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mem_xfer_ctrl.sv
// Sequencer that loads a block into memory A, then copies a strided subset of A into B.
module mem_xfer_ctrl
    import mem_xfer_pkg::*;
#(
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned LOAD_WORDS   = 8,
    parameter int unsigned XFER_WORDS   = 4,
    parameter int unsigned SRC_START    = 1,
    parameter int unsigned STRIDE       = 2,
    parameter int unsigned AUTO_RESTART = 0
) (
    input  logic               clock,
    input  logic               Reset,
    input  logic               start,
    output logic               WEA,
    output logic               IncA,
    output logic               WEB,
    output logic               IncB,
    output logic [ADDR_W-1:0]  addr_a,
    output logic [ADDR_W-1:0]  addr_b,
    output logic               busy,
    output logic               done,
    output logic [PHASE_W-1:0] phase
);

    localparam int unsigned CNT_W = $clog2(XFER_WORDS + 1);

    if (LOAD_WORDS < 1 || LOAD_WORDS > (1 << ADDR_W) ||
        XFER_WORDS < 1 || XFER_WORDS > (1 << ADDR_W) || STRIDE < 1 ||
        SRC_START + (XFER_WORDS - 1) * STRIDE >= LOAD_WORDS) begin : g_bad_params
        $error("mem_xfer_ctrl: illegal parameter combination");
    end

    state_e             state_d;
    state_e             state_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               run_clr;
    logic               go;

    assign go = start || (AUTO_RESTART != 0);

    // Next state; address strobes themselves are pure state decodes below.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    run_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                if (addr_a == ADDR_W'(LOAD_WORDS - 1)) begin
                    state_d = ST_SEEK;
                end
            end
            ST_SEEK: state_d = ST_WRB;
            ST_WRB:  state_d = ST_STEP;
            ST_STEP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(XFER_WORDS)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WRB;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    step_counter #(
        .W    (ADDR_W),
        .STEP (STRIDE)
    ) u_addr_a (
        .clk      (clock),
        .rst      (Reset),
        .clr      (run_clr),
        .ld       (state_q == ST_SEEK),
        .ld_val   (ADDR_W'(SRC_START)),
        .inc_one  (state_q == ST_LOAD),
        .inc_step (state_q == ST_STEP),
        .q        (addr_a)
    );

    step_counter #(
        .W    (ADDR_W),
        .STEP (1)
    ) u_addr_b (
        .clk      (clock),
        .rst      (Reset),
        .clr      (run_clr),
        .ld       (1'b0),
        .ld_val   ('0),
        .inc_one  (state_q == ST_STEP),
        .inc_step (1'b0),
        .q        (addr_b)
    );

    assign WEA   = (state_q == ST_LOAD);
    assign IncA  = (state_q == ST_LOAD) || (state_q == ST_SEEK) || (state_q == ST_STEP);
    assign WEB   = (state_q == ST_WRB);
    assign IncB  = (state_q == ST_STEP);
    assign busy  = (state_q == ST_LOAD) || (state_q == ST_SEEK) ||
                   (state_q == ST_WRB)  || (state_q == ST_STEP);
    assign done  = (state_q == ST_DONE);
    assign phase = state_q;

endmodule
